seg7_reader: RTL and testbench
==============================

Name: seg7_reader

Overview:
- Decodes a pair of 7-segment digit buses, in the codebase's hex-display format, back into an 8-bit binary value. It is the decode direction of the counter/hex-display path.
- It debounces the patterns by requiring them to be stable, rejects illegal patterns, and checks that successive accepted values advance by one.
- It sits on the bench or monitor side, next to the hex-display driver. It can also be used on board to cross-check the displayed count.

Parameters:
- STABLE_CYCLES, default 4: number of consecutive identical samples needed before a pattern is evaluated. Legal range 1..15.

Ports:
- clk  input  1  rising-edge clock
- R  input  1  asynchronous reset, active-high
- hex0  input  7  low digit segments; bit i = segment i (0=a .. 6=g); 1 = segment off
- hex1  input  7  high digit segments, same encoding as hex0
- value  output  8  last accepted value, {hex1 digit, hex0 digit}
- valid  output  1  one-cycle pulse; value was just updated
- bad_code  output  1  one-cycle pulse; a stable pattern was illegal
- step_err  output  1  one-cycle pulse, coincident with valid; accepted value is not last+1 and not 0
- locked  output  1  high once any value has been accepted
- err_count  output  8  saturating count of bad_code and step_err events

Behaviour:
- Decode table: for each digit, the segments that are OFF; all other segments are on.
  - 0: g
  - 1: a,d,e,f,g
  - 2: c,f
  - 3: e,f
  - 4: a,d,e
  - 5: b,e
  - 6: b
  - 7: d,e,f,g
  - 8: none
  - 9: e
  - A: d
  - b: a,b
  - C: b,c,g
  - d: a,f
  - E: b,c
  - F: b,c,d
- Any other 7-bit pattern is illegal, except BLANK (all segments off, 1111111).
- Sampling:
  - Each edge registers {hex1,hex0} into a sample register.
  - run counter: run <= 1 if the new sample differs from the held sample, otherwise run <= min(run+1, STABLE_CYCLES).
  - Stable event: the single cycle in which run first reaches STABLE_CYCLES. It is not repeated while the pattern holds.
- Evaluation is registered on the edge after the stable event, in this priority order:
  - Both digits BLANK: ignored. No pulse, no state change.
  - Either digit illegal, or exactly one digit BLANK: bad_code=1, err_count++ (saturating at 255); value unchanged.
  - Decoded value D equals value while locked: ignored.
  - Otherwise: value<=D, valid=1, locked<=1.
    - If the previous state was locked, D != (value+1) mod 256 and D != 0: step_err=1, err_count++.
    - 255 -> 0 is a legal step. Any -> 0 is legal, because the display counter clears to 0.
- Latency: inputs changed before edge e0 and held → valid high in the cycle following edge e0+STABLE_CYCLES.
- A change of input before STABLE_CYCLES identical samples have been taken restarts run. No pulse is produced (glitch rejection).
- State machine (locked):
  - EMPTY → LOCKED on the first accepted value.
  - LOCKED is held until reset.
  - The step check applies only in LOCKED.
- Reset (async, any time, including mid-debounce):
  - sample <= BLANK/BLANK, run <= 0.
  - value <= 0, valid/bad_code/step_err <= 0, locked <= 0, err_count <= 0.
  - An event in flight when reset asserts is discarded.
  - First evaluation after reset release occurs no earlier than STABLE_CYCLES+1 edges later.
- err_count increments by 2 if bad_code and step_err would both fire. This cannot happen: the two are mutually exclusive by priority, so at most +1 per event.

Decomposition:
- Package seg7_pkg:
  - 16 segment-pattern constants
  - SEG_BLANK = 1111111
  - digit/segment width constants
- Sub-module seg7_decode, combinational:
  - input: 7-bit pattern
  - outputs: 4-bit nibble, legal flag, blank flag
  - instantiated twice, once per digit

Test Plan:
Patterns below are written bit0..bit6.
- Reset, then hex1=0001000 (A), hex0=0000110 (3), held for 5 edges → valid pulse once; value=0xA3; locked=1; step_err=0; err_count=0.
- From value 0x03, apply 0x04 (hex1=0000001, hex0=1001100) → valid, no step_err. Then apply 0x07 → valid, step_err=1, err_count=1.
- value=0xFF, apply 0x00 → valid, step_err=0. Then apply 0x00 again after a blank → no valid (same value).
- hex0=1111110 (illegal) held 4+ edges → exactly one bad_code pulse; value unchanged; err_count +1. Then hex1 blank with hex0=0000001 (0) → bad_code.
- Toggle hex0 between 3 and 4 every 2 edges (STABLE_CYCLES=4) for 20 edges → no valid and no bad_code. Then hold 4 → exactly one valid.
- Assert R asynchronously in the middle of run=3 → all outputs 0 immediately. After release, holding the same pattern yields valid after STABLE_CYCLES+1 edges. Also drive 256 illegal events → err_count saturates at 255.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment reader: widths, the active-low
// hex-display segment patterns (bit i = segment i, a..g; 1 = segment off),
// and the one-bit lock state used by the reader's evaluation FSM.
package seg7_pkg;

  localparam int SEG_W   = 7;
  localparam int DIGIT_W = 4;
  localparam int VALUE_W = 2 * DIGIT_W;

  // Patterns are written [6:0] = g f e d c b a.
  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_A     = 7'b0001000;
  localparam logic [SEG_W-1:0] SEG_B     = 7'b0000011;
  localparam logic [SEG_W-1:0] SEG_C     = 7'b1000110;
  localparam logic [SEG_W-1:0] SEG_D     = 7'b0100001;
  localparam logic [SEG_W-1:0] SEG_E     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_F     = 7'b0001110;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {
    EMPTY  = 1'b0,
    LOCKED = 1'b1
  } lock_state_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational decode of one 7-segment pattern back to its hex nibble.
// legal is set only for the 16 digit glyphs; blank flags the all-off pattern.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0]   pattern,
  output logic [DIGIT_W-1:0] nibble,
  output logic               legal,
  output logic               blank
);

  // Table lookup; anything not in the glyph set is reported as not legal.
  always_comb begin
    nibble = '0;
    legal  = 1'b1;
    blank  = (pattern == SEG_BLANK);
    case (pattern)
      SEG_0:   nibble = 4'h0;
      SEG_1:   nibble = 4'h1;
      SEG_2:   nibble = 4'h2;
      SEG_3:   nibble = 4'h3;
      SEG_4:   nibble = 4'h4;
      SEG_5:   nibble = 4'h5;
      SEG_6:   nibble = 4'h6;
      SEG_7:   nibble = 4'h7;
      SEG_8:   nibble = 4'h8;
      SEG_9:   nibble = 4'h9;
      SEG_A:   nibble = 4'hA;
      SEG_B:   nibble = 4'hB;
      SEG_C:   nibble = 4'hC;
      SEG_D:   nibble = 4'hD;
      SEG_E:   nibble = 4'hE;
      SEG_F:   nibble = 4'hF;
      default: legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_reader.sv
// Reads a two-digit hex display back into an 8-bit value: debounces the
// segment buses, rejects illegal glyphs and flags values that do not
// advance by one from the previous accepted value.
module seg7_reader
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               R,
  input  logic [SEG_W-1:0]   hex0,
  input  logic [SEG_W-1:0]   hex1,
  output logic [VALUE_W-1:0] value,
  output logic               valid,
  output logic               bad_code,
  output logic               step_err,
  output logic               locked,
  output logic [7:0]         err_count
);

  localparam int RUN_W = 4;
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);

  logic [2*SEG_W-1:0] sample;
  logic [RUN_W-1:0]   run, run_next;
  logic               stable, stable_next;
  logic               changed;

  // Run-length of identical samples; the stable event fires once when the
  // run first reaches RUN_MAX (a change restarts it at 1).
  always_comb begin
    changed = ({hex1, hex0} != sample);
    if (changed)
      run_next = 4'd1;
    else if (run == RUN_MAX)
      run_next = RUN_MAX;
    else
      run_next = run + 4'd1;
    stable_next = (run_next == RUN_MAX) && (changed || run != RUN_MAX);
  end

  // Sample register and debounce counter.
  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      sample <= {SEG_BLANK, SEG_BLANK};
      run    <= '0;
      stable <= 1'b0;
    end else begin
      sample <= {hex1, hex0};
      run    <= run_next;
      stable <= stable_next;
    end
  end

  logic [DIGIT_W-1:0] nib_lo, nib_hi;
  logic               legal_lo, legal_hi, blank_lo, blank_hi;

  seg7_decode u_dec_lo (
    .pattern (sample[SEG_W-1:0]),
    .nibble  (nib_lo),
    .legal   (legal_lo),
    .blank   (blank_lo)
  );

  seg7_decode u_dec_hi (
    .pattern (sample[2*SEG_W-1:SEG_W]),
    .nibble  (nib_hi),
    .legal   (legal_hi),
    .blank   (blank_hi)
  );

  lock_state_t        state, state_next;
  logic [VALUE_W-1:0] decoded, value_next;
  logic               valid_next, bad_next, step_next, err_inc;
  logic [7:0]         err_next;
  logic               pattern_bad;

  // Evaluate the stable pattern: blank/blank ignored, bad glyphs flagged,
  // repeats ignored once locked, otherwise accept and step-check.
  always_comb begin
    state_next  = state;
    value_next  = value;
    valid_next  = 1'b0;
    bad_next    = 1'b0;
    step_next   = 1'b0;
    err_inc     = 1'b0;
    decoded     = {nib_hi, nib_lo};
    pattern_bad = (!legal_lo && !blank_lo) || (!legal_hi && !blank_hi) ||
                  (blank_lo ^ blank_hi);
    if (stable) begin
      if (blank_lo && blank_hi) begin
        // display switched off: nothing to read
      end else if (pattern_bad) begin
        bad_next = 1'b1;
        err_inc  = 1'b1;
      end else if (state == LOCKED && decoded == value) begin
        // same value shown again
      end else begin
        value_next = decoded;
        valid_next = 1'b1;
        state_next = LOCKED;
        if (state == LOCKED && decoded != value + 8'd1 && decoded != '0) begin
          step_next = 1'b1;
          err_inc   = 1'b1;
        end
      end
    end
    err_next = (err_inc && err_count != 8'hFF) ? err_count + 8'd1 : err_count;
  end

  // Evaluation state and one-cycle event pulses.
  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      state     <= EMPTY;
      value     <= '0;
      valid     <= 1'b0;
      bad_code  <= 1'b0;
      step_err  <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_next;
      value     <= value_next;
      valid     <= valid_next;
      bad_code  <= bad_next;
      step_err  <= step_next;
      err_count <= err_next;
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_seg7_reader.sv
// Directed bench for seg7_reader: hand-written segment patterns, pulse
// counters sampled on the falling edge, and a single check task.
module tb_seg7_reader;

  // Hand-derived glyphs, [6:0] = g f e d c b a, 1 = segment off.
  localparam logic [6:0] P0  = 7'h40;
  localparam logic [6:0] P3  = 7'h30;
  localparam logic [6:0] P4  = 7'h19;
  localparam logic [6:0] P5  = 7'h12;
  localparam logic [6:0] P7  = 7'h78;
  localparam logic [6:0] PA  = 7'h08;
  localparam logic [6:0] PF  = 7'h0E;
  localparam logic [6:0] BL  = 7'h7F;
  localparam logic [6:0] ILL = 7'h3F;

  logic       clk = 1'b0;
  logic       R = 1'b1;
  logic [6:0] hex0 = BL;
  logic [6:0] hex1 = BL;
  logic [7:0] value;
  logic       valid, bad_code, step_err, locked;
  logic [7:0] err_count;

  seg7_reader #(.STABLE_CYCLES(4)) dut (
    .clk       (clk),
    .R         (R),
    .hex0      (hex0),
    .hex1      (hex1),
    .value     (value),
    .valid     (valid),
    .bad_code  (bad_code),
    .step_err  (step_err),
    .locked    (locked),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cnt_valid = 0, cnt_bad = 0, cnt_step = 0, cnt_step_alone = 0;
  int v0, b0, s0;

  // Count output pulses away from the rising edge.
  always @(negedge clk) begin
    if (valid) cnt_valid <= cnt_valid + 1;
    if (bad_code) cnt_bad <= cnt_bad + 1;
    if (step_err) cnt_step <= cnt_step + 1;
    if (step_err && !valid) cnt_step_alone <= cnt_step_alone + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic snap();
    v0 = cnt_valid;
    b0 = cnt_bad;
    s0 = cnt_step;
  endtask

  task automatic hold(input logic [6:0] h1, input logic [6:0] h0, input int n);
    @(negedge clk);
    hex1 = h1;
    hex0 = h0;
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    repeat (2) @(negedge clk);
    #1;
    check("reset value", value, 8'h00);
    check("reset valid", valid, 0);
    check("reset bad_code", bad_code, 0);
    check("reset step_err", step_err, 0);
    check("reset locked", locked, 0);
    check("reset err_count", err_count, 0);
    @(negedge clk) R = 1'b0;

    // First acceptance from EMPTY: A3
    snap(); hold(PA, P3, 6);
    check("A3 valid pulses", cnt_valid - v0, 1);
    check("A3 value", value, 8'hA3);
    check("A3 locked", locked, 1);
    check("A3 step pulses", cnt_step - s0, 0);
    check("A3 err_count", err_count, 0);

    // Restart from EMPTY, then walk 03 -> 04 -> 07
    @(negedge clk); R = 1'b1; hex1 = BL; hex0 = BL;
    @(negedge clk); R = 1'b0;
    snap(); hold(P0, P3, 6);
    check("03 valid pulses", cnt_valid - v0, 1);
    check("03 value", value, 8'h03);
    check("03 step pulses", cnt_step - s0, 0);
    snap(); hold(P0, P4, 6);
    check("04 valid pulses", cnt_valid - v0, 1);
    check("04 value", value, 8'h04);
    check("04 step pulses", cnt_step - s0, 0);
    snap(); hold(P0, P7, 6);
    check("07 valid pulses", cnt_valid - v0, 1);
    check("07 step pulses", cnt_step - s0, 1);
    check("07 err_count", err_count, 1);

    // 07 -> FF is a bad step; FF -> 00 wraps legally
    snap(); hold(PF, PF, 6);
    check("FF value", value, 8'hFF);
    check("FF step pulses", cnt_step - s0, 1);
    check("FF err_count", err_count, 2);
    snap(); hold(P0, P0, 6);
    check("00 valid pulses", cnt_valid - v0, 1);
    check("00 value", value, 8'h00);
    check("00 step pulses", cnt_step - s0, 0);
    snap(); hold(BL, BL, 6); hold(P0, P0, 6);
    check("blank+repeat valid", cnt_valid - v0, 0);
    check("blank+repeat bad", cnt_bad - b0, 0);
    check("blank+repeat err", err_count, 2);

    // Illegal glyph and half-blank display
    snap(); hold(P0, ILL, 10);
    check("illegal bad pulses", cnt_bad - b0, 1);
    check("illegal value", value, 8'h00);
    check("illegal err_count", err_count, 3);
    snap(); hold(BL, P0, 6);
    check("half blank bad", cnt_bad - b0, 1);
    check("half blank valid", cnt_valid - v0, 0);
    check("half blank err", err_count, 4);

    // Glitching input must not produce any event
    snap();
    for (int i = 0; i < 10; i++) hold(P0, (i % 2 == 1) ? P4 : P3, 2);
    check("glitch valid", cnt_valid - v0, 0);
    check("glitch bad", cnt_bad - b0, 0);
    snap(); hold(P0, P4, 6);
    check("settle valid", cnt_valid - v0, 1);
    check("settle value", value, 8'h04);
    check("settle step", cnt_step - s0, 1);
    check("settle err", err_count, 5);

    // Async reset at run=3, then latency from release
    @(negedge clk); hex1 = P0; hex0 = P5;
    repeat (3) @(posedge clk);
    #2 R = 1'b1;
    #1;
    check("async value", value, 0);
    check("async locked", locked, 0);
    check("async err_count", err_count, 0);
    check("async valid", valid, 0);
    @(negedge clk) R = 1'b0;
    lat = 0;
    for (int k = 1; k <= 12 && lat == 0; k++) begin
      @(posedge clk); #1;
      if (valid) lat = k;
    end
    check("post-reset latency", lat, 5);
    check("post-reset value", value, 8'h05);

    // Saturation of err_count
    @(negedge clk) R = 1'b1;
    @(negedge clk) R = 1'b0;
    snap();
    for (int i = 0; i < 255; i++) hold(P0, (i % 2 == 1) ? BL : ILL, 5);
    check("255 events err", err_count, 255);
    hold(P0, BL, 5);
    check("saturated err", err_count, 255);
    check("saturation bad pulses", cnt_bad - b0, 256);
    check("saturation valid", cnt_valid - v0, 0);
    check("step without valid", cnt_step_alone, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
